muldiv_seq: RTL and testbench
=============================

MULDIV_SEQ -- requirements
Module: muldiv_seq

Interface
REQ-001 SHALL have no parameters; the data width is fixed at 32 bits.
REQ-002 clk  in  1  sole clock; all state updates on the rising edge.
REQ-003 rst_n  in  1  asynchronous, active-low reset.
REQ-004 start  in  1  request strobe, sampled only in IDLE.
REQ-005 op  in  2  00 mult (signed), 01 multu, 10 div (signed), 11 divu.
REQ-006 a, b  in  32 each  multiplicand/multiplier, or dividend/divisor.
REQ-007 busy  out  1  high whenever state is not IDLE.
REQ-008 done  out  1  single-cycle pulse in DONE.
REQ-009 hi, lo  out  32 each  product high/low words, or remainder/quotient.
REQ-010 dbz  out  1  divide-by-zero flag, valid with done.
REQ-011 alu_a, alu_b  out  32 each  operands driven to the shared ALU.
REQ-012 alu_control  out  3  ALU opcode: 010 add, 110 sub, 101 nor.
REQ-013 alu_res  in  32  combinational ALU result, consumed in the same cycle.

Function
REQ-014 States SHALL be IDLE, ABS_A, ABS_B, ITER, NEG_LO, NEG_HI, DONE; DONE always returns to IDLE.
REQ-015 On start in IDLE (cycle T):
- a and b SHALL be latched.
- Unsigned ops SHALL go to ITER.
- Signed ops SHALL go to ABS_A.
- div/divu with b==0 SHALL go directly to DONE.
REQ-016 ABS_A/ABS_B SHALL each take 1 cycle.
- ALU sub with alu_a=0 negates the operand if its bit31 is set; otherwise the operand is held.
- Result signs SHALL be recorded: product sign = a31^b31; quotient sign = a31^b31; remainder sign = a31.
REQ-017 ITER SHALL run exactly 32 cycles, counted by a 5-bit counter.
REQ-018 Multiply iteration:
- Initial state: hi=0, lo=multiplier.
- alu_a=hi, alu_b = lo[0] ? multiplicand : 0, alu_control=add.
- carry = (alu_res < hi, unsigned).
- hi <= {carry, alu_res[31:1]}; lo <= {alu_res[0], lo[31:1]}.
REQ-019 Divide iteration:
- Initial state: hi=0, lo=dividend.
- r = {hi[30:0], lo[31]}.
- alu_a=r, alu_b=divisor, alu_control=sub.
- ge = hi[31] | !(alu_res > r).
- hi <= ge ? alu_res : r; lo <= {lo[30:0], ge}.
REQ-020 Signed ops SHALL always pass through NEG_LO then NEG_HI (1 cycle each); updates are conditional.
- mult, negative sign: NEG_LO sets lo <= 0-lo. NEG_HI sets hi <= 0-hi if the pre-negation lo was 0, else hi <= nor(hi,0).
- div: NEG_LO negates lo if the quotient sign is set. NEG_HI negates hi if the remainder sign is set.
REQ-021 done SHALL be asserted at T+33 for unsigned ops, T+37 for signed ops, and T+1 for divide-by-zero.
REQ-022 Divide-by-zero SHALL produce dbz=1, hi=a, lo=0xFFFFFFFF; dbz SHALL clear on the next accepted start.
REQ-023 div 0x80000000 / 0xFFFFFFFF SHALL yield lo=0x80000000, hi=0 (wrap), dbz=0.
REQ-024 start while busy SHALL be ignored, with no effect on state or outputs.
REQ-025 hi/lo SHALL hold the last result from DONE until the next operation begins updating them.
REQ-026 In IDLE and DONE, alu_a=0, alu_b=0, alu_control=000.

Reset
REQ-027 While rst_n=0: state=IDLE, hi=lo=0, busy=0, done=0, dbz=0, counter=0.
REQ-028 Reset asserted mid-operation SHALL abort it immediately; no done pulse SHALL follow.

Structure
REQ-029 Package muldiv_pkg SHALL hold:
- op encodings
- the state enumeration
- ALU opcode constants (ADD 010, SUB 110, NOR 101, AND 000)
- the iteration count 32
REQ-030 There SHALL be no sub-module; the ALU is external and shared, and the parent instantiates alu and wires it to the alu_* ports.

Verification
REQ-031 multu 0xFFFFFFFF x 0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001, done at T+33.
REQ-032 mult -3 x 7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB, done at T+37.
REQ-033 div -7 / 2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; divu 100/7 -> lo=14, hi=2 at T+33.
REQ-034 divu 100/0 -> done at T+1, dbz=1, hi=100, lo=0xFFFFFFFF; then div 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0, dbz=0.
REQ-035 Start pulses during ITER -> ignored, and the original result is unchanged.
REQ-036 rst_n low at ITER cycle 10 -> all outputs are zero immediately, and no done pulse follows.

Source files
------------

// File: rtl/muldiv_pkg.sv
// Shared encodings for the sequential multiply/divide unit: op codes, FSM states,
// the external ALU opcodes and the iteration count.
package muldiv_pkg;

  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_DIV   = 2'b10,
    OP_DIVU  = 2'b11
  } op_e;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ABS_A  = 3'd1,
    S_ABS_B  = 3'd2,
    S_ITER   = 3'd3,
    S_NEG_LO = 3'd4,
    S_NEG_HI = 3'd5,
    S_DONE   = 3'd6
  } state_e;

  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_NOR = 3'b101;
  localparam logic [2:0] ALU_AND = 3'b000;

  localparam int unsigned ITER_COUNT = 32;
  localparam logic [4:0]  ITER_LAST  = 5'(ITER_COUNT - 1);

  // Bit 1 of the op selects divide, bit 0 selects unsigned.
  function automatic logic op_is_div(input logic [1:0] op);
    return op[1];
  endfunction

  function automatic logic op_is_unsigned(input logic [1:0] op);
    return op[0];
  endfunction

endpackage

// File: rtl/muldiv_seq.sv
// Sequential 32-bit multiply/divide (signed and unsigned) that borrows an external,
// shared combinational ALU for every add/sub/nor it needs.
module muldiv_seq
  import muldiv_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        dbz,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [2:0]  alu_control,
  input  logic [31:0] alu_res
);

  state_e      r_state;
  logic [1:0]  r_op;
  logic [31:0] r_a;
  logic [31:0] r_b;
  logic [31:0] r_hi;
  logic [31:0] r_lo;
  logic [4:0]  r_cnt;
  logic        r_busy;
  logic        r_done;
  logic        r_dbz;
  logic        r_psign;
  logic        r_rsign;
  logic        r_lo_zero;

  logic [31:0] w_rem_shift;
  logic [31:0] w_b_abs;
  logic        w_carry;
  logic        w_ge;
  logic        w_is_div;
  logic [31:0] w_alu_a;
  logic [31:0] w_alu_b;
  logic [2:0]  w_alu_ctl;

  assign w_is_div    = op_is_div(r_op);
  assign w_rem_shift = {r_hi[30:0], r_lo[31]};
  assign w_b_abs     = r_b[31] ? alu_res : r_b;
  assign w_carry     = (alu_res < r_hi);
  // hi[31] means the shifted partial remainder is really 33 bits wide.
  assign w_ge        = r_hi[31] | ~(alu_res > w_rem_shift);

  // ALU operand/opcode selection for the current state
  always_comb begin
    w_alu_a   = 32'd0;
    w_alu_b   = 32'd0;
    w_alu_ctl = ALU_AND;
    case (r_state)
      S_ABS_A: begin
        w_alu_b   = r_a;
        w_alu_ctl = ALU_SUB;
      end
      S_ABS_B: begin
        w_alu_b   = r_b;
        w_alu_ctl = ALU_SUB;
      end
      S_ITER: begin
        if (w_is_div) begin
          w_alu_a   = w_rem_shift;
          w_alu_b   = r_b;
          w_alu_ctl = ALU_SUB;
        end else begin
          w_alu_a   = r_hi;
          w_alu_b   = r_lo[0] ? r_a : 32'd0;
          w_alu_ctl = ALU_ADD;
        end
      end
      S_NEG_LO: begin
        w_alu_b   = r_lo;
        w_alu_ctl = ALU_SUB;
      end
      S_NEG_HI: begin
        // 64-bit negate: the high word only takes the +1 when the low word was zero.
        if (!w_is_div && !r_lo_zero) begin
          w_alu_a   = r_hi;
          w_alu_ctl = ALU_NOR;
        end else begin
          w_alu_b   = r_hi;
          w_alu_ctl = ALU_SUB;
        end
      end
      default: begin
        w_alu_a   = 32'd0;
        w_alu_b   = 32'd0;
        w_alu_ctl = ALU_AND;
      end
    endcase
  end

  // Control FSM with datapath and registered status outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_op      <= 2'b00;
      r_a       <= 32'd0;
      r_b       <= 32'd0;
      r_hi      <= 32'd0;
      r_lo      <= 32'd0;
      r_cnt     <= 5'd0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_dbz     <= 1'b0;
      r_psign   <= 1'b0;
      r_rsign   <= 1'b0;
      r_lo_zero <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_a    <= a;
            r_b    <= b;
            r_op   <= op;
            r_dbz  <= 1'b0;
            r_busy <= 1'b1;
            if (op_is_div(op) && (b == 32'd0)) begin
              r_state <= S_DONE;
              r_hi    <= a;
              r_lo    <= 32'hFFFF_FFFF;
              r_dbz   <= 1'b1;
              r_done  <= 1'b1;
            end else if (op_is_unsigned(op)) begin
              r_state <= S_ITER;
              r_hi    <= 32'd0;
              r_lo    <= op_is_div(op) ? a : b;
            end else begin
              r_state <= S_ABS_A;
            end
          end
        end
        S_ABS_A: begin
          r_psign <= r_a[31] ^ r_b[31];
          r_rsign <= r_a[31];
          if (r_a[31]) r_a <= alu_res;
          r_state <= S_ABS_B;
        end
        S_ABS_B: begin
          r_b     <= w_b_abs;
          r_hi    <= 32'd0;
          r_lo    <= w_is_div ? r_a : w_b_abs;
          r_state <= S_ITER;
        end
        S_ITER: begin
          if (w_is_div) begin
            r_hi <= w_ge ? alu_res : w_rem_shift;
            r_lo <= {r_lo[30:0], w_ge};
          end else begin
            r_hi <= {w_carry, alu_res[31:1]};
            r_lo <= {alu_res[0], r_lo[31:1]};
          end
          if (r_cnt == ITER_LAST) begin
            r_cnt <= 5'd0;
            if (op_is_unsigned(r_op)) begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
            end else begin
              r_state <= S_NEG_LO;
            end
          end else begin
            r_cnt <= r_cnt + 5'd1;
          end
        end
        S_NEG_LO: begin
          r_lo_zero <= (r_lo == 32'd0);
          if (r_psign) r_lo <= alu_res;
          r_state <= S_NEG_HI;
        end
        S_NEG_HI: begin
          if (w_is_div ? r_rsign : r_psign) r_hi <= alu_res;
          r_state <= S_DONE;
          r_done  <= 1'b1;
        end
        S_DONE: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign busy        = r_busy;
  assign done        = r_done;
  assign hi          = r_hi;
  assign lo          = r_lo;
  assign dbz         = r_dbz;
  assign alu_a       = w_alu_a;
  assign alu_b       = w_alu_b;
  assign alu_control = w_alu_ctl;

endmodule

// File: tb/tb_muldiv_seq.sv
// Scoreboard bench for muldiv_seq; also plays the parent that owns the shared ALU.
module tb_muldiv_seq;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [1:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        dbz;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [2:0]  alu_control;
  logic [31:0] alu_res;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dbz;
    int          lat;
    int          t0;
  } exp_t;

  exp_t        sb[$];
  int          total = 0;
  int          bad = 0;
  int          neg_cnt = 0;
  logic        prev_done = 1'b0;
  logic [31:0] last_hi = 32'd0;
  logic [31:0] last_lo = 32'd0;

  muldiv_seq dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b),
    .busy(busy), .done(done), .hi(hi), .lo(lo), .dbz(dbz),
    .alu_a(alu_a), .alu_b(alu_b), .alu_control(alu_control), .alu_res(alu_res)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // External shared ALU
  always_comb begin
    case (alu_control)
      3'b010:  alu_res = alu_a + alu_b;
      3'b110:  alu_res = alu_a - alu_b;
      3'b101:  alu_res = ~(alu_a | alu_b);
      3'b000:  alu_res = alu_a & alu_b;
      default: alu_res = 32'd0;
    endcase
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Returns {dbz, hi, lo}
  function automatic logic [64:0] model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    logic signed [63:0] sx, sy, sp;
    logic signed [31:0] q, r;
    logic [63:0] p;
    model = 65'd0;
    case (o)
      2'b00: begin
        sx = {{32{x[31]}}, x};
        sy = {{32{y[31]}}, y};
        sp = sx * sy;
        model = {1'b0, sp};
      end
      2'b01: begin
        p = {32'd0, x} * {32'd0, y};
        model = {1'b0, p};
      end
      2'b10: begin
        if (y == 32'd0) model = {1'b1, x, 32'hFFFF_FFFF};
        else if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) model = {1'b0, 32'd0, 32'h8000_0000};
        else begin
          q = $signed(x) / $signed(y);
          r = $signed(x) % $signed(y);
          model = {1'b0, r, q};
        end
      end
      default: begin
        if (y == 32'd0) model = {1'b1, x, 32'hFFFF_FFFF};
        else model = {1'b0, x % y, x / y};
      end
    endcase
  endfunction

  // Output monitor: pops the scoreboard on each done pulse
  always @(negedge clk) begin
    exp_t e;
    neg_cnt = neg_cnt + 1;
    if (done && prev_done) check_eq("done_pulse_width", 64'd1, 64'd0);
    if (done) begin
      if (sb.size() == 0) begin
        check_eq("unexpected_done", 64'd1, 64'd0);
      end else begin
        e = sb.pop_front();
        check_eq("hi", {32'd0, hi}, {32'd0, e.hi});
        check_eq("lo", {32'd0, lo}, {32'd0, e.lo});
        check_eq("dbz", {63'd0, dbz}, {63'd0, e.dbz});
        check_eq("latency", 64'(neg_cnt - e.t0), 64'(e.lat));
        last_hi = e.hi;
        last_lo = e.lo;
      end
    end
    prev_done = done;
  end

  task automatic wait_idle();
    int n = 0;
    @(posedge clk); #1;
    while (busy && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    if (busy) check_eq("idle_timeout", 64'd1, 64'd0);
  endtask

  task automatic issue(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    logic [64:0] m;
    exp_t e;
    wait_idle();
    m = model(o, x, y);
    e.dbz = m[64];
    e.hi  = m[63:32];
    e.lo  = m[31:0];
    e.lat = m[64] ? 1 : (o[0] ? 33 : 37);
    e.t0  = neg_cnt + 1;
    sb.push_back(e);
    op = o; a = x; b = y; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    if (sb.size() != 0) begin
      check_eq("done_timeout", 64'(sb.size()), 64'd0);
      sb.delete();
    end
  endtask

  initial begin
    logic [1:0]  ro;
    logic [31:0] rx, ry;
    rst_n = 1'b0; start = 1'b0; op = 2'b00; a = 32'd0; b = 32'd0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_hi", {32'd0, hi}, 64'd0);
    check_eq("rst_lo", {32'd0, lo}, 64'd0);
    check_eq("rst_busy", {63'd0, busy}, 64'd0);
    check_eq("rst_done", {63'd0, done}, 64'd0);
    check_eq("rst_dbz", {63'd0, dbz}, 64'd0);
    rst_n = 1'b1;

    issue(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    issue(2'b00, 32'hFFFF_FFFD, 32'd7);
    issue(2'b10, 32'hFFFF_FFF9, 32'd2);
    issue(2'b11, 32'd100, 32'd7);
    issue(2'b11, 32'd100, 32'd0);
    issue(2'b10, 32'h8000_0000, 32'hFFFF_FFFF);
    issue(2'b10, 32'd5, 32'd0);
    issue(2'b00, 32'h8000_0000, 32'h8000_0000);
    drain();

    // Idle ALU drive and result hold
    repeat (4) @(posedge clk);
    #1;
    check_eq("idle_alu", {29'd0, alu_control, alu_a}, 64'd0);
    check_eq("idle_alu_b", {32'd0, alu_b}, 64'd0);
    check_eq("hold", {hi, lo}, {last_hi, last_lo});

    for (int i = 0; i < 12; i++) begin
      ro = 2'($urandom_range(0, 3));
      rx = $urandom;
      ry = (i % 4 == 3) ? 32'($urandom_range(0, 15)) : $urandom;
      issue(ro, rx, ry);
    end
    drain();

    // Start pulses while busy must be ignored
    issue(2'b01, 32'h1234_5678, 32'h9ABC_DEF0);
    repeat (3) @(posedge clk);
    #1;
    op = 2'b11; a = 32'd1; b = 32'd0; start = 1'b1;
    check_eq("busy_iter", {63'd0, busy}, 64'd1);
    repeat (3) @(posedge clk);
    #1;
    start = 1'b0;
    drain();
    repeat (40) @(posedge clk);
    #1;
    check_eq("ignored_start_hold", {hi, lo}, {last_hi, last_lo});

    // Reset in the middle of ITER aborts without a done pulse
    wait_idle();
    op = 2'b11; a = 32'd1000; b = 32'd3; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check_eq("abort_hilo", {hi, lo}, 64'd0);
    check_eq("abort_flags", {61'd0, busy, done, dbz}, 64'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (45) @(posedge clk);
    #1;
    check_eq("abort_idle", {62'd0, busy, done}, 64'd0);
    check_eq("abort_sb", 64'(sb.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
